// File: rtl/uart_cmd_framer_if.sv
// Byte-stream and command-handshake bundle between the UART receiver,
// the packet framer and the downstream command consumer.
interface uart_cmd_framer_if #(
    parameter int unsigned MAX_LEN = 8
);
    logic                   i_rx_dv;
    logic [7:0]             i_rx_byte;
    logic                   o_cmd_valid;
    logic                   i_cmd_ready;
    logic [7:0]             o_cmd;
    logic [7:0]             o_len;
    logic [8*MAX_LEN-1:0]   o_payload;
    logic                   o_err;
    logic [2:0]             o_err_code;

    modport master (
        output i_rx_dv, i_rx_byte, i_cmd_ready,
        input  o_cmd_valid, o_cmd, o_len, o_payload, o_err, o_err_code
    );

    modport slave (
        input  i_rx_dv, i_rx_byte, i_cmd_ready,
        output o_cmd_valid, o_cmd, o_len, o_payload, o_err, o_err_code
    );
endinterface

// File: rtl/uart_cmd_framer.sv
// Sync-hunting packet framer: assembles SYNC/CMD/LEN/payload/CHK packets,
// checks the XOR checksum and inter-byte timeout, hands packets off via valid/ready.
module uart_cmd_framer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 40,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input logic              clk,
    input logic              rst_n,
    uart_cmd_framer_if.slave bus
);
    localparam int unsigned TW        = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 2);
    localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CHK     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DELIVER
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           len_q, len_d;
    logic [8*MAX_LEN-1:0] payload_q, payload_d;
    logic [7:0]           xor_q, xor_d;
    logic [7:0]           idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [2:0]           code_q, code_d;

    logic       dv;
    logic [7:0] rx;
    logic       in_pkt;

    assign dv     = bus.i_rx_dv;
    assign rx     = bus.i_rx_byte;
    assign in_pkt = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            cmd_q     <= '0;
            len_q     <= '0;
            payload_q <= '0;
            xor_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            payload_q <= payload_d;
            xor_q     <= xor_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        payload_d = payload_q;
        xor_d     = xor_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        err_d     = 1'b0;
        code_d    = code_q;

        // Timeout is flagged one cycle early so the registered pulse lands
        // exactly TIMEOUT_CLKS cycles after the last byte strobe.
        if (in_pkt) begin
            if (dv) begin
                timer_d = '0;
            end else if (timer_q == TO_LAST) begin
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = ST_HUNT;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (dv && rx == SYNC_BYTE) begin
                    state_d   = ST_CMD;
                    payload_d = '0;
                    xor_d     = '0;
                    timer_d   = '0;
                end
            end
            ST_CMD: begin
                if (dv) begin
                    cmd_d   = rx;
                    xor_d   = xor_q ^ rx;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (dv) begin
                    len_d = rx;
                    xor_d = xor_q ^ rx;
                    if (rx > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_HUNT;
                    end else if (rx == 8'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (dv) begin
                    for (int unsigned k = 0; k < MAX_LEN; k++) begin
                        if (idx_q == 8'(k)) begin
                            payload_d[k*8 +: 8] = rx;
                        end
                    end
                    xor_d = xor_q ^ rx;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (dv) begin
                    if (rx == xor_q) begin
                        state_d = ST_DELIVER;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_DELIVER: begin
                // A byte coinciding with acceptance is treated as if already hunting.
                if (bus.i_cmd_ready) begin
                    state_d = ST_HUNT;
                    if (dv && rx == SYNC_BYTE) begin
                        state_d   = ST_CMD;
                        payload_d = '0;
                        xor_d     = '0;
                        timer_d   = '0;
                    end
                end else if (dv) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        valid_d = (state_d == ST_DELIVER);
    end

    assign bus.o_cmd_valid = valid_q;
    assign bus.o_cmd       = cmd_q;
    assign bus.o_len       = len_q;
    assign bus.o_payload   = payload_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_code  = code_q;
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: hand-computed packets covering delivery,
// sync hunting, checksum/length/timeout/overrun errors and async reset.
module tb_uart_cmd_framer;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TO      = 20;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    uart_cmd_framer_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_cmd_framer #(
        .CLKS_PER_BIT (434),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TO),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe one byte for one cycle; returns 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] b);
        bus.i_rx_dv   = 1'b1;
        bus.i_rx_byte = b;
        @(posedge clk);
        #1;
        bus.i_rx_dv   = 1'b0;
        bus.i_rx_byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        bus.i_rx_dv      = 1'b0;
        bus.i_rx_byte    = 8'h00;
        bus.i_cmd_ready  = 1'b1;
        idle(2);

        chk("rst_valid", 64'(bus.o_cmd_valid), 64'd0);
        chk("rst_cmd", 64'(bus.o_cmd), 64'd0);
        chk("rst_len", 64'(bus.o_len), 64'd0);
        chk("rst_payload", bus.o_payload, 64'd0);
        chk("rst_err", 64'(bus.o_err), 64'd0);
        chk("rst_code", 64'(bus.o_err_code), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // Good packet, consumer ready
        send(8'hA5); send(8'h10); send(8'h02); send(8'h3C); send(8'hC3); send(8'hED);
        chk("good_valid", 64'(bus.o_cmd_valid), 64'd1);
        chk("good_cmd", 64'(bus.o_cmd), 64'h10);
        chk("good_len", 64'(bus.o_len), 64'h02);
        chk("good_payload", bus.o_payload, 64'h0000_0000_0000_C33C);
        chk("good_err", 64'(bus.o_err), 64'd0);
        idle(1);
        chk("good_valid_drop", 64'(bus.o_cmd_valid), 64'd0);

        // Garbage before sync, zero-length packet
        send(8'h00); send(8'hFF);
        chk("garbage_err", 64'(bus.o_err), 64'd0);
        send(8'hA5); send(8'h07); send(8'h00);
        chk("zlen_not_yet", 64'(bus.o_cmd_valid), 64'd0);
        send(8'h07);
        chk("zlen_valid", 64'(bus.o_cmd_valid), 64'd1);
        chk("zlen_cmd", 64'(bus.o_cmd), 64'h07);
        chk("zlen_len", 64'(bus.o_len), 64'h00);
        chk("zlen_payload", bus.o_payload, 64'd0);
        idle(1);
        chk("zlen_valid_drop", 64'(bus.o_cmd_valid), 64'd0);

        // Checksum mismatch, then a good packet
        send(8'hA5); send(8'h01); send(8'h01); send(8'h55); send(8'h00);
        chk("chk_err", 64'(bus.o_err), 64'd1);
        chk("chk_code", 64'(bus.o_err_code), 64'd2);
        chk("chk_valid", 64'(bus.o_cmd_valid), 64'd0);
        idle(1);
        chk("chk_err_pulse", 64'(bus.o_err), 64'd0);
        chk("chk_code_hold", 64'(bus.o_err_code), 64'd2);
        send(8'hA5); send(8'h20); send(8'h01); send(8'h11); send(8'h30);
        chk("after_chk_valid", 64'(bus.o_cmd_valid), 64'd1);
        chk("after_chk_payload", bus.o_payload, 64'h0000_0000_0000_0011);
        idle(1);

        // Length above MAX_LEN, trailing bytes ignored
        send(8'hA5); send(8'h01); send(8'h09);
        chk("len_err", 64'(bus.o_err), 64'd1);
        chk("len_code", 64'(bus.o_err_code), 64'd1);
        send(8'h02); send(8'h03); send(8'h01);
        chk("len_ignored_err", 64'(bus.o_err), 64'd0);
        chk("len_ignored_valid", 64'(bus.o_cmd_valid), 64'd0);

        // Timeout: error exactly TO cycles after the last strobe
        send(8'hA5); send(8'h01);
        idle(TO - 2);
        chk("to_early", 64'(bus.o_err), 64'd0);
        idle(1);
        chk("to_err", 64'(bus.o_err), 64'd1);
        chk("to_code", 64'(bus.o_err_code), 64'd3);
        idle(1);
        chk("to_err_pulse", 64'(bus.o_err), 64'd0);

        // Byte on the expiry cycle wins; packet then held with ready low
        send(8'hA5); send(8'h01);
        idle(TO - 2);
        send(8'h00);
        chk("to_race_err", 64'(bus.o_err), 64'd0);
        bus.i_cmd_ready = 1'b0;
        send(8'h01);
        chk("to_race_valid", 64'(bus.o_cmd_valid), 64'd1);
        chk("to_race_cmd", 64'(bus.o_cmd), 64'h01);

        // Overrun while backpressured
        send(8'h55);
        chk("ovr_err", 64'(bus.o_err), 64'd1);
        chk("ovr_code", 64'(bus.o_err_code), 64'd4);
        chk("ovr_valid", 64'(bus.o_cmd_valid), 64'd1);
        chk("ovr_cmd", 64'(bus.o_cmd), 64'h01);
        chk("ovr_len", 64'(bus.o_len), 64'h00);
        idle(1);
        chk("ovr_err_pulse", 64'(bus.o_err), 64'd0);
        chk("ovr_valid_hold", 64'(bus.o_cmd_valid), 64'd1);

        // Accept together with a sync strobe: new packet starts, no overrun
        bus.i_cmd_ready = 1'b1;
        send(8'hA5);
        chk("accept_sync_valid", 64'(bus.o_cmd_valid), 64'd0);
        chk("accept_sync_err", 64'(bus.o_err), 64'd0);
        send(8'h30); send(8'h03); send(8'hAA); send(8'hBB);
        chk("mid_cmd", 64'(bus.o_cmd), 64'h30);
        chk("mid_payload", bus.o_payload, 64'h0000_0000_0000_BBAA);

        // Asynchronous reset mid-payload
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd", 64'(bus.o_cmd), 64'd0);
        chk("arst_len", 64'(bus.o_len), 64'd0);
        chk("arst_payload", bus.o_payload, 64'd0);
        chk("arst_code", 64'(bus.o_err_code), 64'd0);
        idle(1);
        rst_n = 1'b1;
        send(8'hCC); send(8'h11);
        chk("post_rst_hunt_valid", 64'(bus.o_cmd_valid), 64'd0);
        chk("post_rst_hunt_err", 64'(bus.o_err), 64'd0);
        send(8'hA5); send(8'h05); send(8'h00); send(8'h05);
        chk("post_rst_valid", 64'(bus.o_cmd_valid), 64'd1);
        chk("post_rst_cmd", 64'(bus.o_cmd), 64'h05);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
